spi_master_mc: RTL and testbench

SPI_MASTER_MC -- requirements
Module: spi_master_mc

---
 rtl/spi_mc_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 43 ++++
 rtl/spi_master_mc.sv | 143 ++++++++++++++
 tb/tb_spi_master_mc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_mc_pkg.sv
// Shared constants for the multi-chip-select SPI master: state encoding,
// divider width default and legal frame-width range.
package spi_mc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    localparam int DIV_W_DEFAULT = 8;
    localparam int DATA_W_MIN    = 4;
    localparam int DATA_W_MAX    = 32;

    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// sclk divider: half-period of div+1 clk cycles while en is high, with
// one-cycle strobes on the cycle that produces each leading/trailing edge.
module spi_clk_gen
    import spi_mc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    output logic             sclk,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] div_cnt;
    logic             ph;     // 1 = sclk currently away from its idle level
    logic             tick;

    assign tick = en && (div_cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            ph      <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            ph      <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            ph      <= ~ph;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sclk       = cpol ^ ph;
    assign lead_edge  = tick & ~ph;
    assign trail_edge = tick & ph;

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with NUM_CS one-hot chip selects, runtime mode/bit order/divider
// and lead/trail gaps. Optional internal loopback: SPI_MASTER_MC_LOOPBACK_EN.
module spi_master_mc
    import spi_mc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = DIV_W_DEFAULT,
    localparam int CS_W  = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [7:0]        wait_duration,
    input  logic              miso,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done
);

    localparam int EDGE_W = $clog2(2 * DATA_W);

    logic [1:0]        state;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [CS_W-1:0]   sel_q;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        wait_q, wcnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              lead_edge, trail_edge, last_edge;
    logic              mosi_int, rx_bit, do_sample, do_shift;

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_XFER),
        .div        (div_q),
        .cpol       (cpol_q),
        .sclk       (sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    assign busy      = (state != ST_IDLE);
    assign mosi_int  = lsb_q ? tx_sr[0] : tx_sr[DATA_W-1];
    assign mosi      = (state == ST_XFER) & mosi_int;
    assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));

`ifdef SPI_MASTER_MC_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_int : miso;
`else
    assign rx_bit = miso;
`endif

    // cpha=1: the first leading edge only launches the bit already on mosi.
    assign do_sample = cpha_q ? trail_edge : lead_edge;
    assign do_shift  = cpha_q ? (lead_edge && edge_cnt != '0)
                              : (trail_edge && !last_edge);

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (busy && sel_q == CS_W'(i)) cs_n[i] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sel_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            wait_q   <= '0;
            wcnt     <= '0;
            edge_cnt <= '0;
            dout     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    tx_sr    <= din;
                    rx_sr    <= '0;
                    sel_q    <= cs_sel;
                    cpol_q   <= cpol;
                    cpha_q   <= cpha;
                    lsb_q    <= lsb_first;
                    div_q    <= clk_div;
                    wait_q   <= wait_duration;
                    wcnt     <= '0;
                    edge_cnt <= '0;
                    state    <= ST_LEAD;
                end
                ST_LEAD: begin
                    if (wcnt == wait_q) begin
                        wcnt  <= '0;
                        state <= ST_XFER;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (lead_edge || trail_edge) edge_cnt <= edge_cnt + 1'b1;
                    if (do_sample)
                        rx_sr <= lsb_q ? {rx_bit, rx_sr[DATA_W-1:1]}
                                       : {rx_sr[DATA_W-2:0], rx_bit};
                    if (do_shift)
                        tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                    if ((lead_edge || trail_edge) && last_edge) begin
                        wcnt  <= '0;
                        state <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    if (wcnt == wait_q) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        dout  <= rx_sr;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc (DATA_W=12, NUM_CS=4): table of frames
// plus hand sequences for back-to-back start, start-while-busy and reset abort.
module tb_spi_master_mc;

    logic        clk = 1'b0;
    logic        rst, start, cpol, cpha, lsb_first, miso;
    logic [11:0] din;
    logic [1:0]  cs_sel;
    logic [7:0]  clk_div, wait_duration;
    logic        sclk, mosi, busy, done;
    logic [3:0]  cs_n;
    logic [11:0] dout;
    int          miso_mode;  // 0 = echo mosi, 1 = tied 0, 2 = tied 1
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    always #5 clk = ~clk;
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 2);

    spi_master_mc #(.DATA_W(12), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
        .wait_duration(wait_duration), .miso(miso),
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        .loopback(loopback),
`endif
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dout(dout), .busy(busy), .done(done)
    );

    typedef struct {
        logic [11:0] din;
        logic        cpol, cpha, lsb;
        logic [7:0]  div, wt;
        logic [1:0]  sel;
        int          miso_mode;
        logic [11:0] exp_dout;
        logic [3:0]  exp_cs;
    } vec_t;

    int n_pass = 0, n_total = 0;
    int m_edges, m_pre, m_post, m_hmin, m_hmax, m_dones, m_cyc;
    logic [11:0] m_word, m_dout;
    bit m_cs_ok, m_idle_ok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Starts one frame, scrambles the config inputs once the frame is latched,
    // and records what the serial pins did until three cycles after done.
    task automatic run_frame(input vec_t v, input int poke_edge);
        logic prev_sclk, prev_mosi, changed;
        int half, after;
        din = v.din; cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
        clk_div = v.div; wait_duration = v.wt; cs_sel = v.sel; miso_mode = v.miso_mode;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        din = ~v.din; cpol = ~v.cpol; cpha = ~v.cpha; lsb_first = ~v.lsb;
        clk_div = v.div + 8'd2; wait_duration = v.wt + 8'd3; cs_sel = v.sel + 2'd1;
        m_idle_ok = (sclk === v.cpol);
        m_edges = 0; m_pre = 0; m_post = 0; m_hmin = 9999; m_hmax = 0; m_dones = 0;
        m_cyc = 0; m_word = '0; m_dout = 'x; m_cs_ok = 1'b1;
        prev_sclk = sclk; prev_mosi = mosi; half = 0; after = 0;
        while (after < 3 && m_cyc < 4000) begin
            changed = (sclk !== prev_sclk);
            if (busy && cs_n !== v.exp_cs) m_cs_ok = 1'b0;
            if (!busy && cs_n !== 4'hF) m_cs_ok = 1'b0;
            if (changed) begin
                m_edges++;
                if (m_edges > 1) begin
                    if (half < m_hmin) m_hmin = half;
                    if (half > m_hmax) m_hmax = half;
                end
                half = 0;
                m_post = 0;
                // mosi value held just before the edge the slave samples on
                if ((m_edges % 2 == 1) != v.cpha)
                    m_word = v.lsb ? {prev_mosi, m_word[11:1]} : {m_word[10:0], prev_mosi};
            end
            half++;
            if (busy) begin
                if (m_edges == 0) m_pre++;
                m_post++;
            end else if (sclk !== v.cpol || mosi !== 1'b0) begin
                m_idle_ok = 1'b0;
            end
            if (done) begin m_dones++; m_dout = dout; end
            start = (poke_edge > 0 && changed && m_edges == poke_edge);
            if (m_dones > 0) after++;
            prev_sclk = sclk; prev_mosi = mosi;
            @(negedge clk); m_cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        chk({tag, "_timeout"}, (m_cyc >= 4000), 0);
        chk({tag, "_dout"}, m_dout, v.exp_dout);
        chk({tag, "_mosi_word"}, m_word, v.din);
        chk({tag, "_edges"}, m_edges, 24);
        chk({tag, "_half_min"}, m_hmin, v.div + 1);
        chk({tag, "_half_max"}, m_hmax, v.div + 1);
        // LEAD (wait+1) plus the first half-period of XFER before sclk moves
        chk({tag, "_pre"}, m_pre, v.wt + v.div + 2);
        chk({tag, "_post"}, m_post, v.wt + 1);
        chk({tag, "_done_cnt"}, m_dones, 1);
        chk({tag, "_cs_n"}, m_cs_ok, 1);
        chk({tag, "_idle"}, m_idle_ok, 1);
    endtask

    vec_t vecs[6];
    vec_t hv;

    initial begin
        int cyc, dn, e;
        logic prev;

        //             din     cpol  cpha  lsb   div  wt   sel  miso  dout    cs_n
        vecs[0] = '{12'hA5C, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 2'd0, 0, 12'hA5C, 4'b1110};
        vecs[1] = '{12'h00F, 1'b1, 1'b1, 1'b1, 8'd3, 8'd1, 2'd1, 0, 12'h00F, 4'b1101};
        vecs[2] = '{12'h3C6, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 2'd2, 0, 12'h3C6, 4'b1011};
        vecs[3] = '{12'h5A3, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0, 2'd3, 2, 12'hFFF, 4'b0111};
        vecs[4] = '{12'h9F1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 2'd3, 1, 12'h000, 4'b0111};
        vecs[5] = '{12'h871, 1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 2'd0, 0, 12'h871, 4'b1110};

        rst = 1'b1; start = 1'b0; din = '0; cs_sel = '0; cpol = 1'b1; cpha = 1'b0;
        lsb_first = 1'b0; clk_div = '0; wait_duration = '0; miso_mode = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {sclk, mosi, cs_n, busy, done}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0});
        chk("reset_dout", dout, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], -1);
            check_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // start pulsed at the 5th sclk edge: ignored, single done, stays idle
        hv = vecs[0];
        hv.din = 12'h6B2; hv.exp_dout = 12'h6B2;
        run_frame(hv, 5);
        check_frame("poke", hv);
        dn = 0; e = 0;
        repeat (40) @(negedge clk) begin
            if (done) dn++;
            if (busy) e++;
        end
        chk("poke_no_extra_done", dn, 0);
        chk("poke_no_extra_busy", e, 0);

        // start held high: one IDLE cycle (the done cycle) between frames
        din = 12'h2D4; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        wait_duration = 8'd0; cs_sel = 2'd1; miso_mode = 0;
        @(negedge clk); start = 1'b1;
        cyc = 0;
        while (!done && cyc < 500) begin @(negedge clk); cyc++; end
        chk("b2b_first_done", done, 1);
        chk("b2b_idle_at_done", busy, 0);
        chk("b2b_dout", dout, 12'h2D4);
        @(negedge clk);
        chk("b2b_restart", busy, 1);
        start = 1'b0; din = 12'h000;
        cyc = 0;
        while (!done && cyc < 500) begin @(negedge clk); cyc++; end
        chk("b2b_second_done", done, 1);
        chk("b2b_second_dout", dout, 12'h2D4);

        // reset asserted right after the 7th sclk edge
        din = 12'hA5C; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1;
        wait_duration = 8'd1; cs_sel = 2'd2; miso_mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        prev = sclk; e = 0; cyc = 0;
        while (e < 7 && cyc < 500) begin
            @(negedge clk); cyc++;
            if (sclk !== prev) e++;
            prev = sclk;
        end
        chk("rst_reach_edge7", e, 7);
        chk("rst_sclk_high_before", sclk, 1);
        rst = 1'b1; #1;
        chk("rst_mid_outs", {sclk, mosi, cs_n, busy, done}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0});
        chk("rst_mid_dout", dout, 0);
        @(negedge clk); rst = 1'b0;
        dn = 0;
        repeat (60) @(negedge clk) if (done) dn++;
        chk("rst_no_done", dn, 0);
        hv = '{12'h123, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 2'd2, 0, 12'h123, 4'b1011};
        run_frame(hv, -1);
        check_frame("after_rst", hv);

`ifdef SPI_MASTER_MC_LOOPBACK_EN
        loopback = 1'b1;
        hv = '{12'hFFF, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1, 12'hFFF, 4'b1110};
        run_frame(hv, -1);
        check_frame("loopback", hv);
        loopback = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
